// File: rtl/lpdaq_pkg.sv
// Shared types and helpers for the low-power DAQ receive path.
// Holds the frame FSM encoding, ADC word sizes and counter helpers.
package lpdaq_pkg;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    localparam int ADS127_BITS  = 24;
    localparam int LPDAQ_WORD_W = 32;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lpdaq_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A write into a full FIFO is accepted only when a read frees a slot.
module lpdaq_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign do_rd = pop & ~empty;
    assign do_wr = push & (~full | do_rd);

    // Head is forced to zero while empty so the output is clean after reset.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ads127l01_fsync_rx.sv
// ADS127L01 frame-sync receiver: sync, deserialise, sign-extend, buffer.
// Output is an AXI-Stream master fed from a small FWFT FIFO.
module ads127l01_fsync_rx
    import lpdaq_pkg::*;
#(
    parameter int ADC_BITS    = ADS127_BITS,
    parameter int OUT_W       = LPDAQ_WORD_W,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          aclk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sck,
    input  logic                          dout,
    input  logic                          fsync,
    output logic [OUT_W-1:0]              m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   overflow_cnt,
    output logic [15:0]                   frame_err_cnt
);

    localparam int CNT_W = $clog2(ADC_BITS + 1);
    localparam int EXT_W = OUT_W - ADC_BITS;

    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] dout_sr;
    logic [SYNC_STAGES-1:0] fsync_sr;
    logic                   sck_s;
    logic                   dout_s;
    logic                   fsync_s;

    logic                   sck_prev;
    logic                   rise_q;
    logic                   dout_q;
    logic                   fsync_q;
    logic                   fsync_last;
    logic                   armed;
    logic                   fsync_rise;

    rx_state_t              state;
    rx_state_t              state_nx;
    logic [ADC_BITS-1:0]    sh;
    logic [ADC_BITS-1:0]    sh_nx;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       cnt_nx;
    logic                   push;
    logic                   push_nx;
    logic                   abort;

    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [OUT_W-1:0]       wdata;

    assign sck_s   = sck_sr[SYNC_STAGES-1];
    assign dout_s  = dout_sr[SYNC_STAGES-1];
    assign fsync_s = fsync_sr[SYNC_STAGES-1];

    always_ff @(posedge aclk) begin
        if (rst) begin
            sck_sr   <= '0;
            dout_sr  <= '0;
            fsync_sr <= '0;
        end else begin
            sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck};
            dout_sr  <= {dout_sr[SYNC_STAGES-2:0], dout};
            fsync_sr <= {fsync_sr[SYNC_STAGES-2:0], fsync};
        end
    end

    // Data and fsync are registered alongside the edge so all three stay aligned.
    always_ff @(posedge aclk) begin
        if (rst) begin
            sck_prev <= 1'b0;
            rise_q   <= 1'b0;
            dout_q   <= 1'b0;
            fsync_q  <= 1'b0;
        end else begin
            sck_prev <= sck_s;
            rise_q   <= sck_s & ~sck_prev;
            dout_q   <= dout_s;
            fsync_q  <= fsync_s;
        end
    end

    // The first edge after reset only records fsync, so a level already
    // high at release is not mistaken for a frame start.
    always_ff @(posedge aclk) begin
        if (rst) begin
            fsync_last <= 1'b0;
            armed      <= 1'b0;
        end else if (rise_q) begin
            fsync_last <= fsync_q;
            armed      <= 1'b1;
        end
    end

    assign fsync_rise = rise_q & armed & fsync_q & ~fsync_last;

    always_ff @(posedge aclk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RX_IDLE: begin
                if (fsync_rise && en) state_nx = RX_SHIFT;
            end
            RX_SHIFT: begin
                if (rise_q && !fsync_rise &&
                    bit_cnt == CNT_W'(ADC_BITS - 1))
                    state_nx = RX_IDLE;
            end
        endcase
    end

    always_comb begin
        sh_nx   = sh;
        cnt_nx  = bit_cnt;
        push_nx = 1'b0;
        abort   = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (fsync_rise && en) begin
                    sh_nx  = {{(ADC_BITS-1){1'b0}}, dout_q};
                    cnt_nx = CNT_W'(1);
                end
            end
            RX_SHIFT: begin
                if (fsync_rise) begin
                    abort  = 1'b1;
                    sh_nx  = {{(ADC_BITS-1){1'b0}}, dout_q};
                    cnt_nx = CNT_W'(1);
                end else if (rise_q) begin
                    sh_nx  = {sh[ADC_BITS-2:0], dout_q};
                    cnt_nx = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(ADC_BITS - 1)) push_nx = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            sh      <= '0;
            bit_cnt <= '0;
            push    <= 1'b0;
        end else begin
            sh      <= sh_nx;
            bit_cnt <= cnt_nx;
            push    <= push_nx;
        end
    end

    assign wdata = {{EXT_W{sh[ADC_BITS-1]}}, sh};
    assign pop   = m_tvalid & m_tready;

    lpdaq_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk  (aclk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (m_tdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign m_tvalid = ~fifo_empty;

    always_ff @(posedge aclk) begin
        if (rst) begin
            overflow_cnt  <= '0;
            frame_err_cnt <= '0;
        end else begin
            if (push && fifo_full && !pop)
                overflow_cnt <= sat_inc16(overflow_cnt);
            if (abort)
                frame_err_cnt <= sat_inc16(frame_err_cnt);
        end
    end

endmodule
